mem_arbiter: RTL and testbench

Shares the single-ported data memory (one access per cycle, one-cycle registered read latency) between the instruction-fetch requester and the load/store requester of the core. It arbitrates per cycle, bounds data-port priority with a streak counter so fetch cannot starve, and drives the memory port. It routes each response, with its destination-register tag, back to the requester that issued it. It sits between the fetch/memory stages and the memory array.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arb_pick.sv | 49 ++++
 rtl/mem_arbiter.sv | 97 +++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/load-store memory arbiter.
// Holds the response-owner encoding and the registered response record.
package mem_arb_pkg;

  localparam int unsigned WORD_W    = 32;
  // Upper bound on the tag width so the response record can live in the package.
  localparam int unsigned MAX_TAG_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  typedef struct packed {
    owner_e                 owner;
    logic                   we;
    logic [MAX_TAG_W-1:0]   tag;
  } rsp_t;

  localparam rsp_t RSP_IDLE = '{owner: OWN_NONE, we: 1'b0, tag: '0};

endpackage

// File: rtl/mem_arb_pick.sv
// Per-cycle winner selection between fetch and load/store.
// The streak counter bounds how long data can keep fetch waiting.
module mem_arb_pick #(
  parameter int unsigned MaxDstreak = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic fetch_req_i,
  input  logic data_req_i,
  output logic fetch_gnt_o,
  output logic data_gnt_o
);

  localparam int unsigned StreakW = $clog2(MaxDstreak + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MaxDstreak);

  logic [StreakW-1:0] streak_q, streak_d;
  logic               fetch_wins;

  assign fetch_wins = fetch_req_i && (!data_req_i || (streak_q == StreakMax));

  // Grants are held low while reset is asserted, whatever the requests.
  always_comb begin
    fetch_gnt_o = 1'b0;
    data_gnt_o  = 1'b0;
    if (!rst_i) begin
      fetch_gnt_o = fetch_wins;
      data_gnt_o  = data_req_i && !fetch_wins;
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (fetch_gnt_o || !fetch_req_i) begin
      streak_d = '0;
    end else if (data_gnt_o && (streak_q != StreakMax)) begin
      streak_d = streak_q + StreakW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported data memory between instruction fetch and load/store,
// driving the memory port and routing each one-cycle-latency response back.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_AW      = 16,
  parameter int unsigned TAG_W       = 5,
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                i_req,
  input  logic [WORD_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [WORD_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [WORD_W-1:0]   d_addr,
  input  logic [WORD_W-1:0]   d_wd,
  input  logic [TAG_W-1:0]    d_tag,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [WORD_W-1:0]   d_rdata,
  output logic [TAG_W-1:0]    d_tag_out,
  output logic                d_we_out,
  output logic                mem_en,
  output logic                mem_we,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wd,
  input  logic [WORD_W-1:0]   mem_rd
);

  rsp_t rsp_q, rsp_d;

  mem_arb_pick #(
    .MaxDstreak (MAX_DSTREAK)
  ) u_pick (
    .clk_i       (CLK),
    .rst_i       (RST),
    .fetch_req_i (i_req),
    .data_req_i  (d_req),
    .fetch_gnt_o (i_gnt),
    .data_gnt_o  (d_gnt)
  );

  // Memory port follows the winner; byte-offset bits are dropped.
  always_comb begin
    mem_en   = i_gnt | d_gnt;
    mem_we   = d_gnt & d_we;
    mem_addr = d_gnt ? d_addr[MEM_AW+1:2] : i_addr[MEM_AW+1:2];
    mem_wd   = d_gnt ? d_wd : '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_q <= RSP_IDLE;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  always_comb begin
    rsp_d = RSP_IDLE;
    if (i_gnt) begin
      rsp_d.owner = OWN_I;
    end else if (d_gnt) begin
      rsp_d.owner = OWN_D;
      rsp_d.we    = d_we;
      rsp_d.tag   = MAX_TAG_W'(d_tag);
    end
  end

  always_comb begin
    i_rvalid  = 1'b0;
    i_rdata   = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    d_tag_out = '0;
    d_we_out  = 1'b0;
    unique case (rsp_q.owner)
      OWN_I: begin
        i_rvalid = 1'b1;
        i_rdata  = mem_rd;
      end
      OWN_D: begin
        d_rvalid  = 1'b1;
        d_we_out  = rsp_q.we;
        d_tag_out = rsp_q.tag[TAG_W-1:0];
        // Store acks carry no data.
        d_rdata   = rsp_q.we ? '0 : mem_rd;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grants, memory port, response routing,
// streak fairness, mid-operation reset and alternating traffic.
module tb_mem_arbiter;

  localparam int unsigned MEM_AW      = 16;
  localparam int unsigned TAG_W       = 5;
  localparam int unsigned MAX_DSTREAK = 4;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic               i_req, i_gnt, i_rvalid;
  logic [31:0]        i_addr, i_rdata;
  logic               d_req, d_we, d_gnt, d_rvalid, d_we_out;
  logic [31:0]        d_addr, d_wd, d_rdata;
  logic [TAG_W-1:0]   d_tag, d_tag_out;
  logic               mem_en, mem_we;
  logic [MEM_AW-1:0]  mem_addr;
  logic [31:0]        mem_wd;
  logic [31:0]        mem_rd = 32'h0;

  int total = 0;
  int bad   = 0;

  bit [31:0] mem_arr [1024];
  bit        mem_wr  [1024];

  mem_arbiter #(
    .MEM_AW      (MEM_AW),
    .TAG_W       (TAG_W),
    .MAX_DSTREAK (MAX_DSTREAK)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wd      (d_wd),
    .d_tag     (d_tag),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_tag_out (d_tag_out),
    .d_we_out  (d_we_out),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] dflt(input int unsigned a);
    return 32'hA500_0000 | a;
  endfunction

  function automatic logic [31:0] peek(input int unsigned a);
    return mem_wr[a] ? mem_arr[a] : dflt(a);
  endfunction

  // Memory model: one-cycle registered read, write on enable.
  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) begin
        mem_arr[mem_addr[9:0]] <= mem_wd;
        mem_wr[mem_addr[9:0]]  <= 1'b1;
      end else begin
        mem_rd <= peek(int'(mem_addr[9:0]));
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Both requests held: fetch expected on every fifth cycle starting from streak 0.
  // Fetch reads word 0x80, data loads word 0x10.
  task automatic run_streak(input int n);
    for (int k = 0; k < n; k++) begin
      logic exp_i;
      exp_i = ((k % 5) == 4);
      #1;
      chk("streak_i_gnt", i_gnt, exp_i);
      chk("streak_d_gnt", d_gnt, !exp_i);
      chk("streak_mem_en", mem_en, 1'b1);
      @(negedge CLK);
      chk("streak_i_rvalid", i_rvalid, exp_i);
      chk("streak_d_rvalid", d_rvalid, !exp_i);
      if (exp_i) chk("streak_i_rdata", i_rdata, dflt(32'h80));
      else       chk("streak_d_rdata", d_rdata, dflt(32'h10));
    end
  endtask

  initial begin
    i_req  = 1'b1;
    d_req  = 1'b1;
    d_we   = 1'b0;
    i_addr = 32'h0;
    d_addr = 32'h20;
    d_wd   = 32'h0;
    d_tag  = 5'd3;
    RST    = 1'b1;

    // Reset with both requests high.
    #2;
    chk("rst_i_gnt", i_gnt, 1'b0);
    chk("rst_d_gnt", d_gnt, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_i_rvalid", i_rvalid, 1'b0);
    chk("rst_d_rvalid", d_rvalid, 1'b0);
    chk("rst_d_tag_out", d_tag_out, 32'h0);
    chk("rst_d_we_out", d_we_out, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("post_rst_d_gnt", d_gnt, 1'b1);
    chk("post_rst_i_gnt", i_gnt, 1'b0);
    chk("post_rst_mem_addr", mem_addr, 32'h8);

    @(negedge CLK);
    chk("load0_d_rvalid", d_rvalid, 1'b1);
    chk("load0_d_rdata", d_rdata, dflt(32'h8));
    chk("load0_d_tag_out", d_tag_out, 32'd3);
    chk("load0_d_we_out", d_we_out, 1'b0);
    chk("load0_i_rvalid", i_rvalid, 1'b0);

    // Fetch only.
    d_req  = 1'b0;
    i_addr = 32'h0000_0104;
    #1;
    chk("fetch_i_gnt", i_gnt, 1'b1);
    chk("fetch_d_gnt", d_gnt, 1'b0);
    chk("fetch_mem_addr", mem_addr, 32'h41);
    chk("fetch_mem_we", mem_we, 1'b0);
    chk("fetch_mem_en", mem_en, 1'b1);
    @(negedge CLK);
    chk("fetch_i_rvalid", i_rvalid, 1'b1);
    chk("fetch_i_rdata", i_rdata, dflt(32'h41));
    chk("fetch_d_rvalid", d_rvalid, 1'b0);

    // Store then load back.
    i_req  = 1'b0;
    d_req  = 1'b1;
    d_we   = 1'b1;
    d_addr = 32'h10;
    d_wd   = 32'hDEAD_BEEF;
    d_tag  = 5'd7;
    #1;
    chk("store_d_gnt", d_gnt, 1'b1);
    chk("store_mem_we", mem_we, 1'b1);
    chk("store_mem_addr", mem_addr, 32'h4);
    chk("store_mem_wd", mem_wd, 32'hDEAD_BEEF);
    @(negedge CLK);
    chk("store_d_rvalid", d_rvalid, 1'b1);
    chk("store_d_we_out", d_we_out, 1'b1);
    chk("store_d_tag_out", d_tag_out, 32'd7);
    chk("store_d_rdata", d_rdata, 32'h0);
    d_we  = 1'b0;
    d_tag = 5'd9;
    #1;
    chk("reload_mem_we", mem_we, 1'b0);
    @(negedge CLK);
    chk("reload_d_rvalid", d_rvalid, 1'b1);
    chk("reload_d_rdata", d_rdata, 32'hDEAD_BEEF);
    chk("reload_d_we_out", d_we_out, 1'b0);
    chk("reload_d_tag_out", d_tag_out, 32'd9);

    // Both held continuously: D,D,D,D,I repeating.
    i_req  = 1'b1;
    i_addr = 32'h200;
    d_req  = 1'b1;
    d_addr = 32'h40;
    d_tag  = 5'd2;
    run_streak(10);

    // Build streak to 2, then reset right after a load is accepted.
    repeat (2) @(negedge CLK);
    d_tag = 5'd11;
    #1;
    chk("pre_rst_d_gnt", d_gnt, 1'b1);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("midrst_d_rvalid", d_rvalid, 1'b0);
    chk("midrst_d_tag_out", d_tag_out, 32'h0);
    chk("midrst_i_gnt", i_gnt, 1'b0);
    chk("midrst_d_gnt", d_gnt, 1'b0);
    chk("midrst_mem_en", mem_en, 1'b0);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("after_rst_d_rvalid", d_rvalid, 1'b0);
    chk("after_rst_i_rvalid", i_rvalid, 1'b0);
    // Streak restarted at 0: four data grants before fetch.
    run_streak(5);

    // Alternating fetch / load every cycle.
    for (int k = 0; k < 6; k++) begin
      logic is_i;
      is_i = ((k % 2) == 0);
      i_req  = is_i;
      d_req  = !is_i;
      d_we   = 1'b0;
      i_addr = 32'((32'h30 + k) * 4);
      d_addr = 32'((32'h60 + k) * 4);
      d_tag  = TAG_W'(k + 1);
      #1;
      chk("alt_i_gnt", i_gnt, is_i);
      chk("alt_d_gnt", d_gnt, !is_i);
      @(negedge CLK);
      chk("alt_i_rvalid", i_rvalid, is_i);
      chk("alt_d_rvalid", d_rvalid, !is_i);
      if (is_i) begin
        chk("alt_i_rdata", i_rdata, dflt(32'(32'h30 + k)));
      end else begin
        chk("alt_d_rdata", d_rdata, dflt(32'(32'h60 + k)));
        chk("alt_d_tag_out", d_tag_out, 32'(k + 1));
      end
    end

    // Idle: no responses.
    i_req = 1'b0;
    d_req = 1'b0;
    #1;
    chk("idle_mem_en", mem_en, 1'b0);
    @(negedge CLK);
    chk("idle_i_rvalid", i_rvalid, 1'b0);
    chk("idle_d_rvalid", d_rvalid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
